// File: rtl/banco_registros.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Optional same-cycle write-through bypass enabled by defining BANCO_REGISTROS_BYPASS_EN.
module banco_registros #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteReg,
  input  logic [ADDR_W-1:0] DirWrite,
  input  logic [DATA_W-1:0] DatoWB,
  input  logic [ADDR_W-1:0] DirRs,
  input  logic [ADDR_W-1:0] DirRt,
  output logic [DATA_W-1:0] DatoRs,
  output logic [DATA_W-1:0] DatoRt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              writeValid;

  // A commit is real only outside reset and never to r0.
  assign writeValid = WriteReg && !rst && (DirWrite != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (writeValid) begin
      regs[DirWrite] <= DatoWB;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = regs[addr];
`ifdef BANCO_REGISTROS_BYPASS_EN
    if (writeValid && (DirWrite == addr)) value = DatoWB;
`endif
    if (addr == '0) value = '0;
    return value;
  endfunction

  always_comb begin
    DatoRs = readPort(DirRs);
    DatoRt = readPort(DirRt);
  end

endmodule
